up_down_counter_sched: RTL and testbench

//  Shares one WIDTH-bit up/down counter between NUM_REQ requesters.

---
 rtl/counter_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/up_down_counter_sched.sv | 97 +++++++++
 tb/tb_up_down_counter_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: op encodings and FSM state type shared by the counter scheduler.
package counter_pkg;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;
  function automatic logic is_step(input logic [1:0] op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);
  logic [IW-1:0] w_pos;
  // Scan from the farthest offset down so the closest request to ptr is written last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = IW'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_pos]) begin
        o_idx = w_pos;
        o_any = 1'b1;
      end
    end
    o_grant[o_idx] = o_any;
  end
endmodule

// File: rtl/up_down_counter_sched.sv
// up_down_counter_sched: round-robin scheduler for one shared up/down counter;
// multi-step counts run one step per clock and finish with a done pulse.
module up_down_counter_sched
  import counter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [2*NUM_REQ-1:0]     i_req_op,
  input  logic [WIDTH*NUM_REQ-1:0] i_req_arg,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic                     o_busy,
  output logic                     o_done_valid,
  output logic [IW-1:0]            o_done_id,
  output logic                     o_wrap,
  output logic [WIDTH-1:0]         o_count
);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_count, r_rem, w_arg, w_step_cnt;
  logic [IW-1:0]    r_ptr, r_id, w_idx;
  logic [1:0]       r_op, w_op;
  logic [NUM_REQ-1:0] w_gnt;
  logic             r_wrap, w_any, w_accept, w_up, w_cross;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .i_req  (i_req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_comb begin
    w_op  = OP_NOP;
    w_arg = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        w_op  = i_req_op[2*k +: 2];
        w_arg = i_req_arg[WIDTH*k +: WIDTH];
      end
    end
  end

  assign w_accept   = (r_state == IDLE) && w_any;
  assign w_up       = (r_op == OP_UP);
  assign w_step_cnt = w_up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
  assign w_cross    = w_up ? (r_count == '1) : (r_count == '0);

  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_any) w_next = (is_step(w_op) && w_arg != '0) ? EXEC : DONE;
    else if (r_state == EXEC && r_rem == WIDTH'(1)) w_next = DONE;
    else if (r_state == DONE) w_next = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  // Wrap is registered from the step itself, so it shows the cycle after the crossing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_rem   <= '0;
      r_ptr   <= '0;
      r_id    <= '0;
      r_op    <= OP_NOP;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_accept) begin
        r_id  <= w_idx;
        r_op  <= w_op;
        r_rem <= w_arg;
        r_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        if (w_op == OP_LOAD) r_count <= w_arg;
      end
      if (r_state == EXEC) begin
        r_count <= w_step_cnt;
        r_rem   <= r_rem - WIDTH'(1);
        r_wrap  <= w_cross;
      end
    end
  end

  assign o_req_ready  = (r_state == IDLE && i_rst_n) ? w_gnt : '0;
  assign o_busy       = (r_state != IDLE);
  assign o_done_valid = (r_state == DONE);
  assign o_done_id    = r_id;
  assign o_wrap       = r_wrap;
  assign o_count      = r_count;
endmodule

// File: tb/tb_up_down_counter_sched.sv
// tb_up_down_counter_sched: directed stimulus with a queue of expected completions
// checked against each done pulse.
module tb_up_down_counter_sched;
  localparam logic [1:0] NOP = 2'b00, UP = 2'b01, DN = 2'b10, LD = 2'b11;
  typedef struct {
    logic [1:0] id;
    logic [3:0] cnt;
    logic       wr;
    int         dly;
    int         acc;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  valid = '0;
  logic [7:0]  op = '0;
  logic [15:0] arg = '0;
  logic [3:0]  ready, count;
  logic [1:0]  done_id;
  logic        busy, done_valid, wrap;
  int          checks = 0, errors = 0, cyc = 0;
  logic [3:0]  m = '0;
  exp_t        q[$];

  up_down_counter_sched #(.NUM_REQ(4), .WIDTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .i_req_op(op), .i_req_arg(arg),
    .o_req_ready(ready), .o_busy(busy), .o_done_valid(done_valid), .o_done_id(done_id),
    .o_wrap(wrap), .o_count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int r, input logic [1:0] o, input logic [3:0] a);
    valid[r] = 1'b1;
    op[2*r +: 2] = o;
    arg[4*r +: 4] = a;
  endtask

  task automatic push_exp(input int r, input logic [1:0] o, input logic [3:0] a);
    exp_t e;
    e.id = 2'(r);
    e.wr = 1'b0;
    e.dly = 0;
    if (o == LD) m = a;
    else if ((o == UP || o == DN) && a != 0) begin
      m = (o == UP) ? m + a : m - a;
      e.wr = (o == UP) ? (m == 4'd0) : (m == 4'd15);
      e.dly = int'(a);
    end
    e.cnt = m;
    e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic wait_ready();
    bit got = 1'b0;
    #1;
    for (int i = 0; i < 40 && !got; i++) begin
      if (ready != 0) got = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    if (!got) chk("ready_timeout", 32'(ready != 0), 1);
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    exp_t e;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done_valid) got = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    if (!got) chk("done_timeout", 32'(done_valid), 1);
    else if (q.size() == 0) chk("done_unexpected", 32'(q.size()), 1);
    else begin
      e = q.pop_front();
      chk("done_id", 32'(done_id), 32'(e.id));
      chk("done_count", 32'(count), 32'(e.cnt));
      chk("done_wrap", 32'(wrap), 32'(e.wr));
      chk("done_latency", 32'(cyc - e.acc), 32'(e.dly));
    end
  endtask

  task automatic issue(input int r, input logic [1:0] o, input logic [3:0] a);
    drive(r, o, a);
    wait_ready();
    chk("grant", 32'(ready), 32'(1) << r);
    @(posedge clk);
    #1;
    valid[r] = 1'b0;
    push_exp(r, o, a);
  endtask

  task automatic do_reset();
    valid = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done_valid), 0);
    chk("rst_wrap", 32'(wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m = '0;
    q.delete();
    #1;
    chk("rel_count", 32'(count), 0);
    chk("rel_busy", 32'(busy), 0);
    chk("rel_ready", 32'(ready), 0);
    chk("rel_done", 32'(done_valid), 0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    do_reset();
    // reset in the middle of a count abandons it silently
    drive(0, UP, 4'd5);
    wait_ready();
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mid_busy", 32'(busy), 1);
    chk("mid_count", 32'(count), 2);
    do_reset();
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= done_valid;
    end
    chk("mid_no_done", 32'(seen), 0);
    // UP 3 from 0
    issue(0, UP, 4'd3);
    chk("up_rdy_exec", 32'(ready), 0);
    chk("up_busy0", 32'(busy), 1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk("up_count", 32'(count), 32'(k));
      chk("up_busy", 32'(busy), 1);
    end
    wait_done();
    @(posedge clk);
    #1;
    chk("up_idle", 32'(busy), 0);
    chk("up_done_clear", 32'(done_valid), 0);
    // wrap through max
    issue(1, LD, 4'd14);
    chk("ld_wrap", 32'(wrap), 0);
    wait_done();
    issue(2, UP, 4'd3);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk("wrap_seq", 32'(count), 32'((14 + k) % 16));
      chk("wrap_pulse", 32'(wrap), 32'(k == 2));
    end
    wait_done();
    issue(3, LD, 4'd0);
    wait_done();
    issue(0, DN, 4'd1);
    wait_done();
    @(posedge clk);
    #1;
    chk("wrap_one_cycle", 32'(wrap), 0);
    // zero steps and load
    issue(1, UP, 4'd0);
    wait_done();
    issue(2, LD, 4'd9);
    chk("ld_at_accept", 32'(count), 9);
    wait_done();
    // round robin from pointer 0
    @(negedge clk);
    do_reset();
    valid = 4'hF;
    op = '0;
    arg = '0;
    for (int g = 0; g < 5; g++) begin
      wait_ready();
      chk("rr_grant", 32'(ready), 32'(1) << (g % 4));
      @(posedge clk);
      #1;
      push_exp(g % 4, NOP, 4'd0);
      wait_done();
      chk("rr_done_rdy", 32'(ready), 0);
    end
    valid = '0;
    // fairness: move pointer to 3, then 3 and 2 compete
    issue(2, NOP, 4'd0);
    wait_done();
    drive(2, UP, 4'd2);
    drive(3, LD, 4'd5);
    wait_ready();
    chk("fair_3", 32'(ready), 8);
    @(posedge clk);
    #1;
    valid[3] = 1'b0;
    push_exp(3, LD, 4'd5);
    wait_done();
    wait_ready();
    chk("fair_2", 32'(ready), 4);
    @(posedge clk);
    #1;
    valid[2] = 1'b0;
    push_exp(2, UP, 4'd2);
    drive(1, DN, 4'd1);
    #1;
    chk("late_exec_rdy", 32'(ready), 0);
    wait_done();
    chk("late_done_rdy", 32'(ready), 0);
    wait_ready();
    chk("late_grant", 32'(ready), 2);
    @(posedge clk);
    #1;
    valid[1] = 1'b0;
    push_exp(1, DN, 4'd1);
    wait_done();
    chk("sb_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
